layer_2_5_sequencer: RTL and testbench
======================================

# layer_2_5_sequencer

Drives the five-lane multiply-accumulate layer from an input stream. Accepts one term per handshake (one activation plus five weights), issues it to the MAC layer with `load`/`accumulate`, and counts the returned `accumulate_signal` pulses. After `N_TERMS` terms it requantizes the five accumulators (ReLU, shift, saturate) and presents them on a valid/ready output. It then clears the MAC layer for the next output vector.

## Interface
- `VECTOR_SIZE`, 8: weight width (MAC vector lanes).
- `MULTIPLIER_SIZE`, 8: activation width.
- `N_TERMS`, 16: terms accumulated per output vector (≥1).
- `SHIFT`, 4: requantization right-shift.
- `OUT_SIZE`, 8: unsigned output width.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `in_valid` in 1 / `in_ready` out 1: input term handshake.
- `in_weight_1..5` in VECTOR_SIZE: signed weights, one per lane.
- `in_act` in MULTIPLIER_SIZE: signed activation.
- `mul_vector_1..5` out VECTOR_SIZE: to MAC lane vector inputs.
- `mul_multiply` out MULTIPLIER_SIZE: to MAC multiply input.
- `mul_load`, `mul_accumulate` out 1: to MAC load/accumulate.
- `mul_clear` out 1: drives the MAC layer's reset.
- `mul_acc_1..5` in VECTOR_SIZE+MULTIPLIER_SIZE+1: signed MAC accumulators.
- `mul_acc_signal` in 1: MAC one-cycle "term accumulated" pulse.
- `out_valid` out 1 / `out_ready` in 1: output handshake.
- `out_1..5` out OUT_SIZE: requantized results.
- `err` out 1: sticky protocol error.

## Operation
- FSM states: CLEAR, ISSUE, WAIT, OUTPUT.
- **CLEAR** (1 cycle): `mul_clear`=1; zero `issued` and `returned` counters; go to ISSUE.
- **ISSUE**:
  - `in_ready` = (state==ISSUE && issued<N_TERMS).
  - On `in_valid&&in_ready`, register the weights to `mul_vector_k` and `in_act` to `mul_multiply`. Pulse `mul_load`=`mul_accumulate`=1 for exactly the next cycle. Increment `issued`.
  - When `issued` reaches N_TERMS, go to WAIT.
- **WAIT**: entered after the last accept; leave when `returned`==N_TERMS.
- `returned` increments on every `mul_acc_signal` seen in ISSUE or WAIT. The count is independent of pipeline latency. Pulses arriving while issuing are counted.
- When the count completes (the MAC accumulators already include the final term in that cycle):
  - Register the requantized values into `out_k`.
  - Go to OUTPUT.
- **OUTPUT**: `out_valid`=1; `out_k` held stable. On `out_valid&&out_ready`, go to CLEAR.
- Requantization per lane, with acc treated as signed (VECTOR_SIZE+MULTIPLIER_SIZE+1)-bit:
  - acc<0 → 0.
  - Otherwise v = acc>>>SHIFT; v>2^OUT_SIZE−1 → 2^OUT_SIZE−1; else v.
  - Accumulator overflow inside the MAC layer is not detected here.
- `err` is set and held until reset in either case:
  - `mul_acc_signal` arrives in CLEAR or OUTPUT.
  - `returned` would exceed `issued`.
  
  In both cases the stray pulse is not counted.
- `mul_vector_k` and `mul_multiply` hold their last values between issues.

## Timing
- Reset values:
  - state=CLEAR; counters 0.
  - `in_ready`=0, `mul_load`=0, `mul_accumulate`=0.
  - `mul_clear`=1 during reset and the first cycle after it.
  - `mul_vector_k`=0, `mul_multiply`=0.
  - `out_valid`=0, `out_k`=0, `err`=0.
- Reset mid-operation:
  - Any state returns to CLEAR.
  - Partial sums are discarded via `mul_clear`.
  - An in-flight output is dropped.
  - The next frame requires a full N_TERMS.
- Throughput: one term per cycle in ISSUE when `in_valid` is held high. Gaps in `in_valid` are allowed.
- Latency from accept to `mul_load` pulse: 1 cycle.
- `out_valid` rises 1 cycle after the final `mul_acc_signal`.
- Frame overhead: 1 CLEAR cycle after the output handshake. `in_ready`=0 in CLEAR, WAIT and OUTPUT.
- `in_ready` is combinational from state and counters only; it never depends on `in_valid`.
- `out_valid` never depends combinationally on `out_ready`.

## Structure
- Shared package `layer_pkg`:
  - state enum.
  - ACC_WIDTH = VECTOR_SIZE+MULTIPLIER_SIZE+1.
  - requant constant helpers.
- Sub-module `requant_relu_sat` (combinational ReLU/shift/saturate), instantiated five times.
- Counters are $clog2(N_TERMS+1) bits.

## Test plan
Bench uses a behavioural MAC model with configurable latency of 1–5 cycles. Defaults: N_TERMS=4, SHIFT=4.

- **Basic:** all weights 2, act 3, 4 back-to-back terms → each lane acc 24 → `out_k`=1. `out_valid` 1 cycle after the 4th `mul_acc_signal`.
- **ReLU:** weights 8'hFF (−1), act 10, 4 terms → acc −40 → `out_k`=0.
- **Saturation:** weights 127, act 127, 4 terms → acc 64516 → `out_k`=255. A mixed-lane variant checks per-lane independence.
- **Backpressure and gapped input:**
  - `out_ready` low for 5 cycles → `out_k` stable and `in_ready`=0 throughout; transfer on the 6th cycle, then one `mul_clear` cycle.
  - Random `in_valid` gaps → same results as back-to-back.
- **Reset mid-ISSUE:** reset after 2 accepted terms → `mul_clear` asserted. The next frame of 4 terms (weights 1, act 16) gives `out_k`=4, with no contribution from the earlier 2 terms.
- **Protocol error:** inject `mul_acc_signal` in OUTPUT → `err`=1 and held; outputs unchanged; `err` cleared only by reset.

Source files
------------

// File: rtl/layer_pkg.sv
// Shared types and helpers for the five-lane MAC layer sequencer.
package layer_pkg;

  typedef enum logic [1:0] {
    S_CLEAR  = 2'd0,
    S_ISSUE  = 2'd1,
    S_WAIT   = 2'd2,
    S_OUTPUT = 2'd3
  } state_e;

  localparam int unsigned LANES = 5;

  // Accumulator width for a given weight and activation width.
  function automatic int unsigned acc_width(int unsigned vec_w, int unsigned mul_w);
    return vec_w + mul_w + 32'd1;
  endfunction

  // Largest unsigned value representable in w bits.
  function automatic int unsigned sat_max(int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/layer_2_5_sequencer_requant.sv
// Combinational ReLU, arithmetic right shift and unsigned saturation of one accumulator.
module requant_relu_sat
  import layer_pkg::*;
#(
  parameter int unsigned ACC_W    = 17,
  parameter int unsigned SHIFT    = 4,
  parameter int unsigned OUT_SIZE = 8
) (
  input  logic signed [ACC_W-1:0]    acc_i,
  output logic        [OUT_SIZE-1:0] res_o
);

  localparam logic [ACC_W-1:0] MAX_V = ACC_W'(sat_max(OUT_SIZE));

  logic [ACC_W-1:0] shifted;

  // Negative sums clamp to zero; large positive sums clamp to full scale.
  always_comb begin
    shifted = ACC_W'(acc_i >>> SHIFT);
    if (acc_i[ACC_W-1]) begin
      res_o = '0;
    end else if (shifted > MAX_V) begin
      res_o = OUT_SIZE'(MAX_V);
    end else begin
      res_o = shifted[OUT_SIZE-1:0];
    end
  end

endmodule

// File: rtl/layer_2_5_sequencer.sv
// Feeds terms to the five-lane MAC layer, counts returns, requantizes and hands out the vector.
module layer_2_5_sequencer
  import layer_pkg::*;
#(
  parameter int unsigned VECTOR_SIZE     = 8,
  parameter int unsigned MULTIPLIER_SIZE = 8,
  parameter int unsigned N_TERMS         = 16,
  parameter int unsigned SHIFT           = 4,
  parameter int unsigned OUT_SIZE        = 8
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [VECTOR_SIZE-1:0]                 in_weight_1,
  input  logic [VECTOR_SIZE-1:0]                 in_weight_2,
  input  logic [VECTOR_SIZE-1:0]                 in_weight_3,
  input  logic [VECTOR_SIZE-1:0]                 in_weight_4,
  input  logic [VECTOR_SIZE-1:0]                 in_weight_5,
  input  logic [MULTIPLIER_SIZE-1:0]             in_act,
  output logic [VECTOR_SIZE-1:0]                 mul_vector_1,
  output logic [VECTOR_SIZE-1:0]                 mul_vector_2,
  output logic [VECTOR_SIZE-1:0]                 mul_vector_3,
  output logic [VECTOR_SIZE-1:0]                 mul_vector_4,
  output logic [VECTOR_SIZE-1:0]                 mul_vector_5,
  output logic [MULTIPLIER_SIZE-1:0]             mul_multiply,
  output logic                                   mul_load,
  output logic                                   mul_accumulate,
  output logic                                   mul_clear,
  input  logic [VECTOR_SIZE+MULTIPLIER_SIZE:0]   mul_acc_1,
  input  logic [VECTOR_SIZE+MULTIPLIER_SIZE:0]   mul_acc_2,
  input  logic [VECTOR_SIZE+MULTIPLIER_SIZE:0]   mul_acc_3,
  input  logic [VECTOR_SIZE+MULTIPLIER_SIZE:0]   mul_acc_4,
  input  logic [VECTOR_SIZE+MULTIPLIER_SIZE:0]   mul_acc_5,
  input  logic                                   mul_acc_signal,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [OUT_SIZE-1:0]                    out_1,
  output logic [OUT_SIZE-1:0]                    out_2,
  output logic [OUT_SIZE-1:0]                    out_3,
  output logic [OUT_SIZE-1:0]                    out_4,
  output logic [OUT_SIZE-1:0]                    out_5,
  output logic                                   err
);

  localparam int unsigned ACC_W = acc_width(VECTOR_SIZE, MULTIPLIER_SIZE);
  localparam int unsigned CW    = $clog2(N_TERMS + 1);

  state_e                     state_q, state_d;
  logic [CW-1:0]              issued_q, issued_d;
  logic [CW-1:0]              returned_q, returned_d;
  logic [VECTOR_SIZE-1:0]     vec_q [LANES];
  logic [VECTOR_SIZE-1:0]     vec_d [LANES];
  logic [VECTOR_SIZE-1:0]     in_w  [LANES];
  logic [MULTIPLIER_SIZE-1:0] mult_q, mult_d;
  logic                       load_q, load_d;
  logic                       out_valid_q, out_valid_d;
  logic [OUT_SIZE-1:0]        out_q [LANES];
  logic [OUT_SIZE-1:0]        out_d [LANES];
  logic [OUT_SIZE-1:0]        req   [LANES];
  logic [ACC_W-1:0]           acc_in[LANES];
  logic                       err_q, err_d;
  logic                       accept;

  assign in_w[0]   = in_weight_1;
  assign in_w[1]   = in_weight_2;
  assign in_w[2]   = in_weight_3;
  assign in_w[3]   = in_weight_4;
  assign in_w[4]   = in_weight_5;
  assign acc_in[0] = mul_acc_1;
  assign acc_in[1] = mul_acc_2;
  assign acc_in[2] = mul_acc_3;
  assign acc_in[3] = mul_acc_4;
  assign acc_in[4] = mul_acc_5;

  // One requantizer per lane, always looking at the live accumulators.
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    requant_relu_sat #(
      .ACC_W   (ACC_W),
      .SHIFT   (SHIFT),
      .OUT_SIZE(OUT_SIZE)
    ) u_rq (
      .acc_i(acc_in[g]),
      .res_o(req[g])
    );
  end

  assign in_ready = (state_q == S_ISSUE) && (issued_q < CW'(N_TERMS));
  assign accept   = in_valid && in_ready;

  // Next-state, counters, issue registers, result capture and error flag.
  always_comb begin
    state_d     = state_q;
    issued_d    = issued_q;
    returned_d  = returned_q;
    vec_d       = vec_q;
    mult_d      = mult_q;
    load_d      = 1'b0;
    out_valid_d = out_valid_q;
    out_d       = out_q;
    err_d       = err_q;
    case (state_q)
      S_CLEAR: begin
        issued_d    = '0;
        returned_d  = '0;
        out_valid_d = 1'b0;
        if (mul_acc_signal) err_d = 1'b1;
        state_d     = S_ISSUE;
      end
      S_ISSUE, S_WAIT: begin
        if (accept) begin
          vec_d    = in_w;
          mult_d   = in_act;
          load_d   = 1'b1;
          issued_d = issued_q + CW'(1);
          if (issued_q == CW'(N_TERMS - 1)) state_d = S_WAIT;
        end
        // A return with nothing outstanding is flagged and not counted.
        if (mul_acc_signal) begin
          if (returned_q >= issued_q) begin
            err_d = 1'b1;
          end else begin
            returned_d = returned_q + CW'(1);
            if (returned_q == CW'(N_TERMS - 1)) begin
              out_d       = req;
              out_valid_d = 1'b1;
              state_d     = S_OUTPUT;
            end
          end
        end
      end
      S_OUTPUT: begin
        if (mul_acc_signal) err_d = 1'b1;
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_CLEAR;
        end
      end
      default: state_d = S_CLEAR;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_CLEAR;
      issued_q    <= '0;
      returned_q  <= '0;
      vec_q       <= '{default: '0};
      mult_q      <= '0;
      load_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_q       <= '{default: '0};
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      issued_q    <= issued_d;
      returned_q  <= returned_d;
      vec_q       <= vec_d;
      mult_q      <= mult_d;
      load_q      <= load_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      err_q       <= err_d;
    end
  end

  // MAC reset covers the reset cycles and the CLEAR cycle that follows.
  assign mul_clear      = reset || (state_q == S_CLEAR);
  assign mul_load       = load_q;
  assign mul_accumulate = load_q;
  assign mul_multiply   = mult_q;
  assign mul_vector_1   = vec_q[0];
  assign mul_vector_2   = vec_q[1];
  assign mul_vector_3   = vec_q[2];
  assign mul_vector_4   = vec_q[3];
  assign mul_vector_5   = vec_q[4];
  assign out_valid      = out_valid_q;
  assign out_1          = out_q[0];
  assign out_2          = out_q[1];
  assign out_3          = out_q[2];
  assign out_4          = out_q[3];
  assign out_5          = out_q[4];
  assign err            = err_q;

endmodule

// File: tb/tb_layer_2_5_sequencer.sv
// Randomized bench for layer_2_5_sequencer with a behavioural MAC and frame-level model.
module tb_layer_2_5_sequencer;

  localparam int N  = 4;
  localparam int SH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [7:0]  in_weight_1, in_weight_2, in_weight_3, in_weight_4, in_weight_5;
  logic [7:0]  in_act;
  logic [7:0]  mul_vector_1, mul_vector_2, mul_vector_3, mul_vector_4, mul_vector_5;
  logic [7:0]  mul_multiply;
  logic        mul_load, mul_accumulate, mul_clear;
  logic [16:0] mul_acc_1, mul_acc_2, mul_acc_3, mul_acc_4, mul_acc_5;
  logic        mul_acc_signal;
  logic        out_valid, out_ready;
  logic [7:0]  out_1, out_2, out_3, out_4, out_5;
  logic        err;

  always #5 clk = ~clk;

  layer_2_5_sequencer #(
    .VECTOR_SIZE(8), .MULTIPLIER_SIZE(8), .N_TERMS(N), .SHIFT(SH), .OUT_SIZE(8)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_weight_1(in_weight_1), .in_weight_2(in_weight_2), .in_weight_3(in_weight_3),
    .in_weight_4(in_weight_4), .in_weight_5(in_weight_5), .in_act(in_act),
    .mul_vector_1(mul_vector_1), .mul_vector_2(mul_vector_2), .mul_vector_3(mul_vector_3),
    .mul_vector_4(mul_vector_4), .mul_vector_5(mul_vector_5), .mul_multiply(mul_multiply),
    .mul_load(mul_load), .mul_accumulate(mul_accumulate), .mul_clear(mul_clear),
    .mul_acc_1(mul_acc_1), .mul_acc_2(mul_acc_2), .mul_acc_3(mul_acc_3),
    .mul_acc_4(mul_acc_4), .mul_acc_5(mul_acc_5), .mul_acc_signal(mul_acc_signal),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_1(out_1), .out_2(out_2), .out_3(out_3), .out_4(out_4), .out_5(out_5),
    .err(err)
  );

  int ntests = 0;
  int nfail  = 0;
  logic chk_en = 1'b0;
  logic exp_err = 1'b0;
  int exp_o[5];
  int tw[N][5];
  int ta[N];
  int facc[5];

  wire [7:0] dout[5];
  wire [7:0] mvec[5];
  assign dout[0] = out_1; assign dout[1] = out_2; assign dout[2] = out_3;
  assign dout[3] = out_4; assign dout[4] = out_5;
  assign mvec[0] = mul_vector_1; assign mvec[1] = mul_vector_2; assign mvec[2] = mul_vector_3;
  assign mvec[3] = mul_vector_4; assign mvec[4] = mul_vector_5;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int ref_q(int acc);
    int v;
    if (acc < 0) return 0;
    v = acc / (1 << SH);
    return (v > 255) ? 255 : v;
  endfunction

  function automatic int s8(logic [7:0] v);
    return int'($signed(v));
  endfunction

  // Behavioural MAC: each load lands in the accumulators mac_lat cycles later with a pulse.
  typedef struct { int p[5]; int cnt; } mterm_t;
  mterm_t mq[$];
  int mac_acc[5];
  int mac_lat = 1;
  int cyc = 0;
  int pulse_cyc = -100;
  logic inject = 1'b0;

  assign mul_acc_1 = 17'(mac_acc[0]);
  assign mul_acc_2 = 17'(mac_acc[1]);
  assign mul_acc_3 = 17'(mac_acc[2]);
  assign mul_acc_4 = 17'(mac_acc[3]);
  assign mul_acc_5 = 17'(mac_acc[4]);

  initial begin
    mul_acc_signal = 1'b0;
    for (int k = 0; k < 5; k++) mac_acc[k] = 0;
  end

  always @(posedge clk) begin
    mterm_t t;
    #1;
    cyc++;
    mul_acc_signal = 1'b0;
    if (mul_clear === 1'b1) begin
      for (int k = 0; k < 5; k++) mac_acc[k] = 0;
      mq.delete();
    end else begin
      for (int i = 0; i < mq.size(); i++) mq[i].cnt = mq[i].cnt - 1;
      if (mq.size() > 0 && mq[0].cnt <= 0) begin
        t = mq.pop_front();
        for (int k = 0; k < 5; k++) mac_acc[k] = mac_acc[k] + t.p[k];
        mul_acc_signal = 1'b1;
        pulse_cyc = cyc;
      end
      if (mul_load === 1'b1) begin
        for (int k = 0; k < 5; k++) t.p[k] = s8(mvec[k]) * s8(mul_multiply);
        t.cnt = mac_lat;
        mq.push_back(t);
      end
      if (inject) begin
        mul_acc_signal = 1'b1;
        inject = 1'b0;
      end
    end
  end

  // Every cycle: sticky error flag and, whenever offered, the output vector.
  always @(negedge clk) begin
    #1;
    if (chk_en && reset === 1'b0) begin
      check("err", 32'(err), 32'(exp_err));
      if (out_valid === 1'b1)
        for (int k = 0; k < 5; k++) check($sformatf("out_%0d", k + 1), 32'(dout[k]), 32'(exp_o[k]));
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; exp_err = 1'b0;
    @(negedge clk); #1;
    check("clear_in_reset", 32'(mul_clear), 1);
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_mul_load", 32'(mul_load), 0);
    check("rst_mul_acc", 32'(mul_accumulate), 0);
    check("rst_vector_1", 32'(mul_vector_1), 0);
    check("rst_multiply", 32'(mul_multiply), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_1", 32'(out_1), 0);
    check("rst_err", 32'(err), 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("clear_first_cycle", 32'(mul_clear), 1);
    check("in_ready_clear", 32'(in_ready), 0);
    @(negedge clk); #1;
    check("clear_done", 32'(mul_clear), 0);
    check("in_ready_issue", 32'(in_ready), 1);
  endtask

  task automatic fill_const(int w, int a);
    for (int n = 0; n < N; n++) begin
      ta[n] = a;
      for (int k = 0; k < 5; k++) tw[n][k] = w;
    end
  endtask

  task automatic fill_rand();
    for (int n = 0; n < N; n++) begin
      ta[n] = int'($urandom_range(0, 254)) - 127;
      for (int k = 0; k < 5; k++) tw[n][k] = int'($urandom_range(0, 254)) - 127;
    end
  endtask

  // Offer terms until cnt are accepted; accumulates the ideal lane sums in facc.
  task automatic feed_terms(int cnt, int gap_pct);
    int n = 0;
    int budget = 0;
    for (int k = 0; k < 5; k++) facc[k] = 0;
    while (n < cnt && budget < 200) begin
      in_valid = ($urandom_range(0, 99) >= gap_pct);
      in_act = 8'(ta[n]);
      in_weight_1 = 8'(tw[n][0]); in_weight_2 = 8'(tw[n][1]); in_weight_3 = 8'(tw[n][2]);
      in_weight_4 = 8'(tw[n][3]); in_weight_5 = 8'(tw[n][4]);
      #1;
      check("in_ready_feed", 32'(in_ready), 1);
      if (in_valid && in_ready === 1'b1) begin
        for (int k = 0; k < 5; k++) facc[k] += tw[n][k] * ta[n];
        n++;
      end
      @(negedge clk);
      budget++;
    end
    in_valid = 1'b0;
    if (n < cnt) check("feed_timeout", 32'(n), 32'(cnt));
  endtask

  task automatic run_frame(int gap_pct, int bp, int inj, int lit1);
    int budget = 0;
    feed_terms(N, gap_pct);
    for (int k = 0; k < 5; k++) exp_o[k] = ref_q(facc[k]);
    #1;
    while (out_valid !== 1'b1 && budget < 60) begin
      check("in_ready_wait", 32'(in_ready), 0);
      @(negedge clk); #1;
      budget++;
    end
    check("out_valid_rise", 32'(out_valid), 1);
    check("out_valid_latency", 32'(cyc), 32'(pulse_cyc + 1));
    if (lit1 >= 0) check("out_1_literal", 32'(out_1), 32'(lit1));
    for (int i = 0; i < bp; i++) begin
      if (inj != 0 && i == 0) inject = 1'b1;
      check("bp_out_valid", 32'(out_valid), 1);
      check("bp_in_ready", 32'(in_ready), 0);
      @(negedge clk);
      if (inj != 0 && i == 1) exp_err = 1'b1;
      #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    check("out_valid_drop", 32'(out_valid), 0);
    check("clear_after_hs", 32'(mul_clear), 1);
    check("in_ready_clear", 32'(in_ready), 0);
    @(negedge clk); #1;
    check("clear_one_cycle", 32'(mul_clear), 0);
    check("in_ready_next", 32'(in_ready), 1);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_act = '0;
    in_weight_1 = '0; in_weight_2 = '0; in_weight_3 = '0; in_weight_4 = '0; in_weight_5 = '0;
    do_reset();
    chk_en = 1'b1;

    fill_const(2, 3);      mac_lat = 1; run_frame(0, 0, 0, 1);
    fill_const(-1, 10);    mac_lat = 3; run_frame(0, 0, 0, 0);
    fill_const(127, 127);  mac_lat = 5; run_frame(0, 0, 0, 255);

    // Mixed lanes: saturate, negative, mid-range, small, saturate.
    for (int n = 0; n < N; n++) begin
      ta[n] = 127;
      tw[n][0] = 127; tw[n][1] = -128; tw[n][2] = 3; tw[n][3] = 1; tw[n][4] = 64;
    end
    mac_lat = 2; run_frame(0, 0, 0, 255);

    fill_rand();           mac_lat = 4; run_frame(0, 5, 0, -1);
    fill_const(2, 3);      mac_lat = 3; run_frame(40, 0, 0, 1);

    repeat (8) begin
      fill_rand();
      mac_lat = int'($urandom_range(1, 5));
      run_frame(int'($urandom_range(0, 60)), int'($urandom_range(0, 4)), 0, -1);
    end

    // Reset after two accepted terms; next frame must not see them.
    fill_const(50, 50); mac_lat = 2;
    feed_terms(2, 0);
    do_reset();
    fill_const(1, 16); run_frame(0, 0, 0, 4);

    // Stray return during OUTPUT sets a sticky error that survives the next frame.
    fill_rand(); mac_lat = 2; run_frame(0, 5, 1, -1);
    fill_const(2, 3); run_frame(20, 2, 0, 1);
    do_reset();
    fill_const(1, 16); mac_lat = 5; run_frame(30, 1, 0, 4);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish by %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
